// File: rtl/cdc_handshake_sender_pkg.sv
// Shared types and default constants for the four-phase CDC handshake sender.
`timescale 1ns/1ps
package cdc_handshake_sender_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH          = 8;
    localparam int DEFAULT_STAGES         = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/cdc_handshake_sender_sync.sv
// fast_synchronizer: STAGES-deep flip-flop chain for a single asynchronous bit.
`timescale 1ns/1ps
module fast_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_sender.sv
// Source-side four-phase request/acknowledge CDC controller.
// Optional watchdog enabled by defining CDC_HANDSHAKE_SENDER_TIMEOUT_EN.
`timescale 1ns/1ps
module cdc_handshake_sender
    import cdc_handshake_sender_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int STAGES         = DEFAULT_STAGES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_valid,
    output logic             write_ready,
    output logic [WIDTH-1:0] cdc_data,
    output logic             cdc_request,
    input  logic             cdc_acknowledge,
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    output logic             timeout_error,
`endif
    output logic             busy
);

    if (STAGES < 1) begin : g_bad_stages
        $error("STAGES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    logic   ack_sync;
    logic   accept;

    fast_synchronizer #(
        .STAGES (STAGES)
    ) u_ack_sync (
        .clock  (clock),
        .resetn (~reset),
        .d      (cdc_acknowledge),
        .q      (ack_sync)
    );

    // A stale acknowledge from an un-reset receiver must not let a new word in.
    assign write_ready = (state == IDLE) && !ack_sync;
    assign accept      = write_valid && write_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cdc_request <= 1'b0;
            cdc_data    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cdc_data    <= write_data;
                        cdc_request <= 1'b1;
                        busy        <= 1'b1;
                        state       <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (ack_sync) begin
                        cdc_request <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_sync) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cdc_request <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_count;
    logic             enter_wait;

    assign enter_wait = (state == IDLE && accept) || (state == REQUEST && ack_sync);

    // Watchdog only reports; the handshake keeps waiting for the receiver.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_count    <= '0;
            timeout_error <= 1'b0;
        end else if (enter_wait) begin
            wait_count <= '0;
        end else if (state != IDLE && wait_count != LIMIT) begin
            wait_count <= wait_count + 1'b1;
            if (wait_count + 1'b1 == LIMIT) begin
                timeout_error <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Randomised self-checking bench for cdc_handshake_sender with a behavioural remote receiver.
`timescale 1ns/1ps
module tb_cdc_handshake_sender;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`else
    localparam int TIMEOUT_CYCLES = 1024;
`endif
    localparam int LAT = STAGES + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] write_data = '0;
    logic             write_valid = 1'b0;
    logic             write_ready;
    logic [WIDTH-1:0] cdc_data;
    logic             cdc_request;
    logic             cdc_acknowledge = 1'b0;
    logic             busy;
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    logic             timeout_error;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] exp_q[$];

    cdc_handshake_sender #(
        .WIDTH          (WIDTH),
        .STAGES         (STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .write_data      (write_data),
        .write_valid     (write_valid),
        .write_ready     (write_ready),
        .cdc_data        (cdc_data),
        .cdc_request     (cdc_request),
        .cdc_acknowledge (cdc_acknowledge),
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
        .timeout_error   (timeout_error),
`endif
        .busy            (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Wait (bounded) for cdc_request to appear; returns at the negedge that first shows it.
    task automatic wait_request(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cdc_request) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Remote receiver: raise ack ack_dly cycles after seeing request, drop it rel_dly cycles
    // after request falls. Reports edges from ack change to the sender's reaction.
    task automatic remote_complete(input int ack_dly, input int rel_dly, input logic [WIDTH-1:0] held,
                                   output int n_fall, output int n_ready, output bit stable);
        stable = 1'b1;
        repeat (ack_dly) begin
            @(negedge clock);
            if (cdc_data !== held || cdc_request !== 1'b1) stable = 1'b0;
        end
        cdc_acknowledge = 1'b1;
        n_fall = 0;
        while (n_fall < 50) begin
            @(negedge clock);
            n_fall++;
            if (cdc_data !== held) stable = 1'b0;
            if (cdc_request === 1'b0) break;
        end
        repeat (rel_dly) begin
            @(negedge clock);
            if (cdc_data !== held || cdc_request !== 1'b0 || write_ready !== 1'b0) stable = 1'b0;
        end
        cdc_acknowledge = 1'b0;
        n_ready = 0;
        while (n_ready < 50) begin
            @(negedge clock);
            n_ready++;
            if (cdc_data !== held) stable = 1'b0;
            if (write_ready === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        write_data = 8'h5A;
        write_valid = 1'b1;
        wait_request(ok);
        write_valid = 1'b0;
        vectors++;
        if (!ok || cdc_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL reset_preload: request=%b data=%h required request=1 data=5a", cdc_request, cdc_data);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({cdc_request, busy, write_ready} !== 3'b001 || cdc_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: req/busy/ready=%b data=%h required 001 data=00",
                     {cdc_request, busy, write_ready}, cdc_data);
        end
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
        vectors++;
        if (timeout_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_timeout_flag: got %b required 0", timeout_error);
        end
`endif
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        bit ok, stable;
        int n_fall, n_ready;
        write_data = 8'hA5;
        write_valid = 1'b1;
        wait_request(ok);
        write_valid = 1'b0;
        write_data = 8'h00;
        vectors++;
        if (!ok || cdc_data !== 8'hA5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept: request=%b data=%h busy=%b required 1 a5 1", cdc_request, cdc_data, busy);
        end
        remote_complete(3, 3, 8'hA5, n_fall, n_ready, stable);
        vectors++;
        if (n_fall !== LAT) begin
            miscompares++;
            $display("FAIL single_req_fall: %0d edges, required %0d", n_fall, LAT);
        end
        vectors++;
        if (n_ready !== LAT || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready: %0d edges busy=%b, required %0d busy=0", n_ready, busy, LAT);
        end
        vectors++;
        if (stable !== 1'b1) begin
            miscompares++;
            $display("FAIL single_stable: stable=%b required 1", stable);
        end
    endtask

    task automatic test_held_data();
        bit ok, stable;
        int n_fall, n_ready;
        write_data = 8'hA5;
        write_valid = 1'b1;
        wait_request(ok);
        write_data = 8'h3C;
        remote_complete(3, 3, 8'hA5, n_fall, n_ready, stable);
        vectors++;
        if (!ok || stable !== 1'b1 || n_ready !== LAT) begin
            miscompares++;
            $display("FAIL held_first: ok=%b stable=%b ready_edges=%0d required 1 1 %0d", ok, stable, n_ready, LAT);
        end
        @(negedge clock);
        write_valid = 1'b0;
        vectors++;
        if (cdc_request !== 1'b1 || cdc_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL held_second_accept: request=%b data=%h required 1 3c", cdc_request, cdc_data);
        end
        remote_complete(3, 3, 8'h3C, n_fall, n_ready, stable);
        vectors++;
        if (n_fall !== LAT || n_ready !== LAT || stable !== 1'b1) begin
            miscompares++;
            $display("FAIL held_second_done: fall=%0d ready=%0d stable=%b required %0d %0d 1",
                     n_fall, n_ready, stable, LAT, LAT);
        end
    endtask

    task automatic test_stale_ack();
        bit stable;
        int n_fall, n_ready, bad, n;
        cdc_acknowledge = 1'b1;
        repeat (4) @(negedge clock);
        vectors++;
        if (write_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_ready: got %b required 0", write_ready);
        end
        write_data = 8'h77;
        write_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (busy !== 1'b0 || cdc_request !== 1'b0 || write_ready !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stale_blocked: %0d cycles left idle, required 0", bad);
        end
        cdc_acknowledge = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (write_ready === 1'b1) break;
        end
        vectors++;
        if (n != STAGES) begin
            miscompares++;
            $display("FAIL stale_release: ready after %0d edges, required %0d", n, STAGES);
        end
        @(negedge clock);
        write_valid = 1'b0;
        vectors++;
        if (cdc_request !== 1'b1 || cdc_data !== 8'h77) begin
            miscompares++;
            $display("FAIL stale_accept: request=%b data=%h required 1 77", cdc_request, cdc_data);
        end
        remote_complete(3, 3, 8'h77, n_fall, n_ready, stable);
    endtask

    task automatic test_mid_reset();
        bit ok;
        write_data = 8'hE1;
        write_valid = 1'b1;
        wait_request(ok);
        write_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (!ok || cdc_request !== 1'b0 || busy !== 1'b0 || cdc_data !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: ok=%b request=%b busy=%b data=%h required 1 0 0 00",
                     ok, cdc_request, busy, cdc_data);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (write_ready !== 1'b1 || cdc_request !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_idle: ready=%b request=%b required 1 0", write_ready, cdc_request);
        end
    endtask

    task automatic test_random();
        bit ok, stable;
        int n_fall, n_ready, gap, idle_bad, lat_bad, stab_bad;
        logic [WIDTH-1:0] d, got, expd;
        idle_bad = 0;
        lat_bad = 0;
        stab_bad = 0;
        for (int t = 0; t < 25; t++) begin
            gap = $urandom_range(0, 4);
            write_valid = 1'b0;
            repeat (gap) begin
                write_data = WIDTH'($urandom);
                @(negedge clock);
                if (cdc_request !== 1'b0 || busy !== 1'b0) idle_bad++;
            end
            d = WIDTH'($urandom);
            exp_q.push_back(d);
            write_data = d;
            write_valid = 1'b1;
            wait_request(ok);
            write_valid = 1'b0;
            write_data = ~d;
            got = cdc_data;
            expd = exp_q.pop_front();
            vectors++;
            if (!ok || got !== expd) begin
                miscompares++;
                $display("FAIL random_data[%0d]: got %h required %h (request seen=%b)", t, got, expd, ok);
            end
            remote_complete($urandom_range(1, 5), $urandom_range(1, 5), expd, n_fall, n_ready, stable);
            if (n_fall != LAT || n_ready != LAT) lat_bad++;
            if (!stable) stab_bad++;
        end
        vectors++;
        if (lat_bad != 0) begin
            miscompares++;
            $display("FAIL random_latency: %0d transfers off, required 0", lat_bad);
        end
        vectors++;
        if (stab_bad != 0 || idle_bad != 0) begin
            miscompares++;
            $display("FAIL random_stability: %0d unstable, %0d idle glitches, required 0 0", stab_bad, idle_bad);
        end
    endtask

`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        write_data = 8'h99;
        write_valid = 1'b1;
        wait_request(ok);
        write_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (timeout_error === 1'b1) break;
        end
        vectors++;
        if (!ok || n != TIMEOUT_CYCLES) begin
            miscompares++;
            $display("FAIL timeout_cycles: flag after %0d cycles, required %0d", n, TIMEOUT_CYCLES);
        end
        repeat (3) @(negedge clock);
        vectors++;
        if (cdc_request !== 1'b1 || timeout_error !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_hold: request=%b flag=%b required 1 1", cdc_request, timeout_error);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (timeout_error !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: got %b required 0", timeout_error);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_held_data();
        test_stale_ack();
        test_mid_reset();
        test_random();
`ifdef CDC_HANDSHAKE_SENDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
